// File: rtl/serial_alu.sv
// Digit-serial ALU: AND/OR/ADD/SLT over WIDTH bits, DIGIT bits per cycle, ripple carry held in c_q.
// Optional flag outputs (zero, carry_out, overflow) are built when SERIAL_ALU_FLAGS_EN is defined.
module serial_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef SERIAL_ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
`endif
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              c_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [3:0]        op_q;

  int unsigned       base;
  logic              last;
  logic [DIGIT-1:0]  da, db, dand, dor, dsum, dig;
  logic [DIGIT:0]    carr;
  logic              v, less;
  logic [WIDTH-1:0]  res_next;

  assign last = (cnt_q == CntW'(N - 1));

  always_comb begin
    base = DIGIT * 32'(cnt_q);
    da   = a_q[base +: DIGIT] ^ {DIGIT{op_q[3]}};
    db   = b_q[base +: DIGIT] ^ {DIGIT{op_q[2]}};
    dand = da & db;
    dor  = da | db;
    dsum = '0;
    carr = '0;
    carr[0] = c_q;
    // Carry uses the inverted operands so SUB/SLT get a proper two's-complement chain.
    for (int i = 0; i < int'(DIGIT); i++) begin
      dsum[i]   = da[i] ^ db[i] ^ carr[i];
      carr[i+1] = (da[i] & db[i]) | (da[i] & carr[i]) | (db[i] & carr[i]);
    end
    case (op_q[1:0])
      2'b00:   dig = dand;
      2'b01:   dig = dor;
      default: dig = dsum;
    endcase
    v    = carr[DIGIT] ^ carr[DIGIT-1];
    less = dsum[DIGIT-1] ^ v;
    res_next = result;
    res_next[base +: DIGIT] = dig;
    if (last && (op_q[1:0] == 2'b11)) begin
      res_next = {{(WIDTH-1){1'b0}}, less};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      c_q       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      result    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= alu_op;
            c_q      <= alu_op[2];
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          result <= res_next;
          c_q    <= carr[DIGIT];
          cnt_q  <= cnt_q + CntW'(1);
          if (last) begin
            state_q   <= StDone;
            out_valid <= 1'b1;
`ifdef SERIAL_ALU_FLAGS_EN
            zero      <= (res_next == '0);
            carry_out <= carr[DIGIT];
            overflow  <= op_q[1] ? v : 1'b0;
`endif
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_alu.md
# serial_alu

Parametrised, digit-serial successor to the single-bit ALU slice. It processes a WIDTH-bit operation DIGIT bits per clock, carrying the ripple carry in a register between cycles. It sits beside the execute stage of the multi-cycle processor and trades latency for area. The ALUOp encoding and semantics match the existing slice, with SLT added and both operands inverted correctly in the carry path.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of DIGIT.
- DIGIT, 4: bits processed per BUSY cycle; N = WIDTH/DIGIT cycles per operation. DIGIT = WIDTH gives 1-cycle operation.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  high only in IDLE; request accepted on the edge where in_valid & in_ready.
- a  in  WIDTH  operand A, sampled at acceptance.
- b  in  WIDTH  operand B, sampled at acceptance.
- alu_op  in  4  [3] Ainvert, [2] Binvert, [1:0] op: 00 AND, 01 OR, 10 ADD, 11 SLT; sampled at acceptance.
- out_valid  out  1  result available; held until out_ready.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  result; stable while out_valid.
- zero, carry_out, overflow  out  1 each  present only with SERIAL_ALU_FLAGS_EN.

## Operation
- FSM states: IDLE → BUSY → DONE → IDLE.
- IDLE: in_ready = 1. On accept, latch a, b, and alu_op. Set carry register c = alu_op[2] (Binvert), set cnt = 0, and go to BUSY.
- BUSY: each edge processes digit cnt (bits [cnt*DIGIT +: DIGIT]) and increments cnt.
  - ma = Ainvert ? ~a : a; mb = Binvert ? ~b : b.
  - Per bit: and = ma & mb; or = ma | mb; sum = ma ^ mb ^ c.
  - Bit carry = majority(ma, mb, c), computed on the *inverted* operands.
  - c updates to the digit's carry-out. The result digit is written per op.
  - When cnt = N-1 is processed, go to DONE.
- SLT (op 11): the BUSY pass computes the full sum internally. On entry to DONE, result = {WIDTH-1 zeros, less}, where less = sum[WIDTH-1] ^ V and V = carry into MSB ^ carry out of MSB.
- DONE: out_valid = 1. On out_ready, go to IDLE. in_ready stays 0 in DONE, so an accept cannot happen in the same cycle as a result handoff.
- Common encodings:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT
  - 1100 NOR
- Other encodings are legal and follow the datapath literally.
- in_valid while not in IDLE is ignored; operands are not re-sampled.
- result holds its last value in IDLE until the next operation overwrites it digit by digit. Consumers use it only while out_valid = 1.

## Timing
- Reset (async, any state, including mid-BUSY) forces:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - result = 0, cnt = 0, c = 0.
  - Flags = 0.
- A partially computed operation is discarded; nothing is emitted after reset release.
- Latency: out_valid rises N edges after the acceptance edge (8 cycles for 32/4).
- Throughput: one operation per N+2 cycles at best. The two extra cycles are the accept cycle and the DONE cycle with out_ready = 1.
- No combinational path from in_valid or out_ready to any output other than the documented handshake outputs (which are registered or state-decoded).

## Configuration
- SERIAL_ALU_FLAGS_EN defined:
  - Adds ports zero, carry_out, and overflow, registered and valid with out_valid.
  - zero = (result == 0).
  - carry_out = final carry c.
  - overflow = V for ADD/SLT-type ops, 0 for AND/OR.
- SERIAL_ALU_FLAGS_EN undefined: the ports and flag logic are absent; all other behaviour is identical.

## Test plan
- ADD 0010, a=32'h0000_0005, b=32'h0000_0003 → out_valid exactly 8 cycles after accept, result=32'h0000_0008, carry_out=0, zero=0.
- SUB 0110, a=5, b=7 → result=32'hFFFF_FFFE, overflow=0.
- SUB 0110, a=b=32'h1234_5678 → result=0, zero=1, carry_out=1.
- SLT 0111, a=32'hFFFF_FFFF, b=1 → result=1; repeat with a=32'h7FFF_FFFF, b=32'h8000_0000 → result=0 (overflow-corrected).
- ADD 0010, a=32'h7FFF_FFFF, b=1 → result=32'h8000_0000, overflow=1. NOR 1100, a=32'hF0F0_F0F0, b=32'h0F0F_0000 → result=32'h0000_0F0F.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE → result and out_valid are stable, in_ready=0, and in_valid pulses are ignored.
  - Assert rst_n=0 at BUSY cnt=3 → all outputs are at reset values immediately.
  - After release, a new ADD 1+1 returns 2.
  - Rerun the suite with DIGIT=1, 8, and 32 (latency 32, 4, and 1).
